// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the data-memory access stage: funct3 access codes,
// access-size codes used by the lane aligner, the access FSM state encoding and
// a helper that classifies an access as illegal (conflicting controls, unknown
// size, or misaligned halfword/word).
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    // funct3 access size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size as carried in funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when a presented access may not be issued to memory.
    // Only meaningful when at least one of rd/wr is set.
    function automatic logic access_illegal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic bad;
        bad = rd & wr;
        case (f3)
            F3_B, F3_BU: bad = bad;
            F3_H, F3_HU: bad = bad | lo[0];
            F3_W:        bad = bad | (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the data-memory port.
//   Store side: st_size_i (funct3[1:0]), st_addr_lo_i, st_data_i in;
//               st_be_o byte enables and lane-replicated st_wdata_o out.
//   Load side:  ld_funct3_i, ld_addr_lo_i (latched at accept), raw ld_rdata_i
//               in; ld_data_o selected and sign/zero-extended word out.
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store byte enables and replicated write data by access size
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = 32'h0000_0000;
        case (st_size_i)
            SZ_B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                if (st_addr_lo_i[1]) begin
                    st_be_o = 4'b1100;
                end else begin
                    st_be_o = 4'b0011;
                end
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_W: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
            default: begin
                st_be_o    = 4'b0000;
                st_wdata_o = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (ld_addr_lo_i)
            2'b00:   byte_s = ld_rdata_i[7:0];
            2'b01:   byte_s = ld_rdata_i[15:8];
            2'b10:   byte_s = ld_rdata_i[23:16];
            2'b11:   byte_s = ld_rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (ld_addr_lo_i[1]) begin
            half_s = ld_rdata_i[31:16];
        end else begin
            half_s = ld_rdata_i[15:0];
        end
    end

    // Sign- or zero-extend the selected lane(s) to a full word
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ld_data_o = {24'h00_0000, byte_s};
            F3_H:    ld_data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   ld_data_o = {16'h0000, half_s};
            F3_W:    ld_data_o = ld_rdata_i;
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access unit of the RV32 pipeline. Accepts a load or
// store from the forwarding mux, issues it on a req/ack memory port with
// byte lanes, stalls the pipeline while it is outstanding, and registers the
// extended load result plus the destination into the MEM/WB register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   Mem_Read/Mem_Write/...     access controls, address, store data, rd, we
//   Dmem_Req/We/Addr/WData/BE  registered memory request, held until ack
//   Dmem_Ack/Dmem_RData        memory completion and read word
//   Mem_Stall                  hold IF..MEM while an access is in flight
//   Mem_Exc                    registered one-cycle illegal-access pulse
//   Wb_Mem_ReadData/Wb_Rd/Wb_RegWrite  MEM/WB register outputs
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Mem_Read,
    input  logic              Mem_Write,
    input  logic [2:0]        Mem_Funct3,
    input  logic [ADDR_W-1:0] Mem_Addr,
    input  logic [31:0]       Mux_Mem_WriteData,
    input  logic [4:0]        Mem_Rd,
    input  logic              Mem_RegWrite,
    output logic              Dmem_Req,
    output logic              Dmem_We,
    output logic [ADDR_W-1:0] Dmem_Addr,
    output logic [31:0]       Dmem_WData,
    output logic [3:0]        Dmem_BE,
    input  logic              Dmem_Ack,
    input  logic [31:0]       Dmem_RData,
    output logic              Mem_Stall,
    output logic              Mem_Exc,
    output logic [31:0]       Wb_Mem_ReadData,
    output logic [4:0]        Wb_Rd,
    output logic              Wb_RegWrite
);

    state_t state_q, state_d;

    logic              access_s;
    logic              illegal_s;
    logic              accept_s;
    logic              capture_s;
    logic              stall_s;
    logic              exc_d;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic              exc_q;
    logic [31:0]       rdata_q;
    logic [4:0]        wb_rd_q;
    logic              wb_rw_q;

    logic [3:0]        st_be_s;
    logic [31:0]       st_wdata_s;
    logic [31:0]       ld_data_s;

    assign access_s  = Mem_Read | Mem_Write;
    assign illegal_s = access_s &
                       access_illegal(Mem_Read, Mem_Write, Mem_Funct3, Mem_Addr[1:0]);

    // Store lanes come from the live inputs (latched at accept); load lanes
    // use the latched funct3/offset because the read word arrives later.
    mem_lane_align u_align (
        .st_size_i    (Mem_Funct3[1:0]),
        .st_addr_lo_i (Mem_Addr[1:0]),
        .st_data_i    (Mux_Mem_WriteData),
        .st_be_o      (st_be_s),
        .st_wdata_o   (st_wdata_s),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (lo_q),
        .ld_rdata_i   (Dmem_RData),
        .ld_data_o    (ld_data_s)
    );

    // Access FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, stall and capture strobes
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        stall_s   = 1'b0;
        exc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                exc_d = illegal_s;
                if (access_s && !illegal_s) begin
                    stall_s  = 1'b1;
                    accept_s = 1'b1;
                    state_d  = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (Dmem_Ack) begin
                    capture_s = ~we_q;
                    state_d   = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            // The pipeline advances this cycle; never re-accept the same
            // instruction that is still sitting on the inputs.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latches, exception pulse, load result and MEM/WB register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            be_q    <= 4'b0000;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            exc_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            wb_rd_q <= 5'd0;
            wb_rw_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
            if (accept_s) begin
                addr_q <= {Mem_Addr[ADDR_W-1:2], 2'b00};
                we_q   <= Mem_Write;
                f3_q   <= Mem_Funct3;
                lo_q   <= Mem_Addr[1:0];
                if (Mem_Write) begin
                    wdata_q <= st_wdata_s;
                    be_q    <= st_be_s;
                end else begin
                    wdata_q <= 32'h0000_0000;
                    be_q    <= 4'b0000;
                end
            end
            if (capture_s) begin
                rdata_q <= ld_data_s;
            end
            if (!stall_s) begin
                wb_rd_q <= Mem_Rd;
                wb_rw_q <= Mem_RegWrite & ~exc_d;
            end
        end
    end

    // Request is a decode of the state register, so reset drops it at once
    assign Dmem_Req        = (state_q == REQ);
    assign Dmem_We         = we_q;
    assign Dmem_Addr       = addr_q;
    assign Dmem_WData      = wdata_q;
    assign Dmem_BE         = be_q;
    assign Mem_Stall       = stall_s;
    assign Mem_Exc         = exc_q;
    assign Wb_Mem_ReadData = rdata_q;
    assign Wb_Rd           = wb_rd_q;
    assign Wb_RegWrite     = wb_rw_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage of the RV32 pipeline, sitting directly downstream of the MEM-stage store-data forwarding mux. Consumes the forwarded store data, address and access controls, drives a request/acknowledge data-memory port with byte lanes, stalls the pipeline while the access is outstanding, and registers the aligned, extended load result into the MEM/WB register. That result is the value fed back for mem-to-mem forwarding.

## Interface
Parameters:
- ADDR_W, 32, data-memory byte-address width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- Mem_Read  in  1  load in MEM stage
- Mem_Write  in  1  store in MEM stage
- Mem_Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Mem_Addr  in  ADDR_W  effective byte address
- Mux_Mem_WriteData  in  32  forwarded store data, low bits significant
- Mem_Rd  in  5  destination register
- Mem_RegWrite  in  1  destination write enable
- Dmem_Req  out  1  request valid, registered
- Dmem_We  out  1  1 = store
- Dmem_Addr  out  ADDR_W  word-aligned address, bits [1:0] = 0
- Dmem_WData  out  32  lane-replicated store data
- Dmem_BE  out  4  byte enables; 0000 on loads
- Dmem_Ack  in  1  memory completes the access this cycle
- Dmem_RData  in  32  read word, valid with Dmem_Ack
- Mem_Stall  out  1  hold IF..MEM stages
- Mem_Exc  out  1  one-cycle pulse: misaligned or illegal access
- Wb_Mem_ReadData  out  32  extended load result
- Wb_Rd  out  5  MEM/WB destination
- Wb_RegWrite  out  1  MEM/WB write enable

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, no access (Mem_Read = Mem_Write = 0): Mem_Stall = 0. Instruction passes to MEM/WB at the clock edge.
- IDLE, legal access:
  - Mem_Stall = 1 combinationally.
  - At the edge, latch Dmem_Addr, Dmem_We, Dmem_WData, Dmem_BE, funct3 and addr[1:0], then enter REQ.
- REQ: Dmem_Req = 1 and Mem_Stall = 1. All Dmem_* outputs are held stable until Dmem_Ack. On Dmem_Ack, capture the extended load data (loads only), then enter DONE.
- DONE: Mem_Stall = 0, no request. The pipeline advances at this edge. Return to IDLE unconditionally, so the held instruction is never reissued.
- Illegal access: both Mem_Read and Mem_Write set, funct3 in {011, 110, 111}, H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
  - No bus request and no stall.
  - Mem_Exc pulses for one cycle.
  - Wb_RegWrite is forced to 0 for that instruction.
- Store lanes:
  - SB: BE = 0001 << addr[1:0], WData = byte ×4.
  - SH: BE = 0011 when addr[1] = 0, otherwise 1100; WData = half ×2.
  - SW: BE = 1111.
- Load extension: select lane(s) by the latched addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- MEM/WB register (Wb_Rd, Wb_RegWrite) loads on every edge where Mem_Stall = 0.
- Wb_Mem_ReadData holds its last value across non-load instructions.

## Timing
- Reset values: state IDLE; every output 0, including Dmem_Addr, Dmem_WData, Dmem_BE, Wb_Mem_ReadData and Mem_Exc.
- Reset asserted in REQ or DONE:
  - Return to IDLE immediately; Dmem_Req drops asynchronously.
  - A later Dmem_Ack while in IDLE is ignored.
- Minimum access occupancy is 3 cycles: accept (cycle 0), REQ with same-cycle ack (cycle 1), DONE (cycle 2).
- Each extra wait cycle of memory adds one stall cycle.
- Wb_Mem_ReadData is valid from the edge ending REQ, so it is stable throughout DONE and on the following cycle.
- Dmem_Ack outside REQ: ignored.
- Non-memory instructions: 1-cycle MEM→WB latency, no stall.
- Mem_Exc is registered: it goes high in the cycle after the illegal instruction is presented.

## Structure
- Shared package holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encodings: IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2.
- One combinational sub-module, mem_lane_align, handles:
  - store: funct3 and addr[1:0] in, BE and replicated WData out.
  - load: funct3, addr[1:0] and raw word in, extended word out.
- FSM and MEM/WB registers live in the top module.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, ack on first REQ cycle → Dmem_Addr 0x100, BE 1111, WData 0xDEADBEEF; Mem_Stall high for exactly 2 cycles.
- SB, addr 0x203, data 0x000000A5 → Dmem_Addr 0x200, BE 1000, WData 0xA5A5A5A5, Dmem_We 1.
- LB at 0x301, RData 0x0000_80_00, i.e. byte 1 = 0x80 → Wb_Mem_ReadData 0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- LH at 0x402, ack delayed 3 cycles, RData 0x7FFF1234 → Dmem_Req held 4 cycles with stable outputs; Wb_Mem_ReadData 0x00007FFF; Mem_Stall high for 5 cycles.
- LW at 0x501 → no Dmem_Req, Mem_Stall 0, Mem_Exc pulse next cycle, Wb_RegWrite 0.
- Reset asserted in REQ, then Dmem_Ack arrives after reset release → Dmem_Req 0 at once, all outputs 0, state IDLE, ack ignored.
